// File: rtl/hdmi_pattern_gen.sv
// hdmi_pattern_gen: self-timed video test-pattern source for the TMDS encoder.
// Generates raster timing from its own x/y counters, picks one of several
// patterns per frame and presents RGB, syncs, DE and position one pixclk later.
module hdmi_pattern_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int COLOR_W    = 8,
  parameter int CNT_W      = 12,
  parameter int CHECK_LOG2 = 5,
  parameter bit SYNC_POL   = 1'b0
) (
  input  logic                   pixclk,
  input  logic                   reset,
  input  logic [2:0]             mode,
  input  logic                   scroll_en,
  input  logic [3*COLOR_W-1:0]   solid_rgb,
  output logic [COLOR_W-1:0]     red,
  output logic [COLOR_W-1:0]     green,
  output logic [COLOR_W-1:0]     blue,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   de,
  output logic [CNT_W-1:0]       cntX,
  output logic [CNT_W-1:0]       cntY,
  output logic                   frame_start,
  output logic [7:0]             frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // Only the low bits of the scrolled x are ever looked at, so the adder is
  // sized to cover the checker bit and the grey-ramp bits and nothing more.
  localparam int XS_W = (CHECK_LOG2 + 1 > COLOR_W) ? CHECK_LOG2 + 1 : COLOR_W;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_L  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_L  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] H_HALF   = CNT_W'(H_ACTIVE / 2);
  localparam logic [CNT_W-1:0] V_HALF   = CNT_W'(V_ACTIVE / 2);
  localparam logic [CNT_W-1:0] HS_BEG   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(H_ACTIVE / 8 - 1);
  localparam logic [COLOR_W-1:0] FULL   = {COLOR_W{1'b1}};

  // ---------------------------------------------------------------------
  // Raster counters, bar sub-counter, frame counter and per-frame settings
  // ---------------------------------------------------------------------
  logic [CNT_W-1:0]     x_q, x_d;
  logic [CNT_W-1:0]     y_q, y_d;
  logic [CNT_W-1:0]     bar_px_q, bar_px_d;
  logic [2:0]           bar_idx_q, bar_idx_d;
  logic [7:0]           frame_cnt_q, frame_cnt_d;
  logic [2:0]           mode_q, mode_d;
  logic                 scroll_q, scroll_d;
  logic [3*COLOR_W-1:0] solid_q, solid_d;

  logic x_wrap;
  logic y_wrap;
  logic at_origin;

  // Next raster position; the frame settings follow the live inputs only on
  // the (0,0) cycle, so the *_d values are also what governs the current pixel
  always_comb begin
    x_wrap    = (x_q == H_LAST);
    y_wrap    = (y_q == V_LAST);
    at_origin = (x_q == '0) && (y_q == '0);

    x_d = x_wrap ? '0 : x_q + 1'b1;

    y_d = y_q;
    if (x_wrap) begin
      y_d = y_wrap ? '0 : y_q + 1'b1;
    end

    frame_cnt_d = frame_cnt_q;
    if (x_wrap && y_wrap) begin
      frame_cnt_d = frame_cnt_q + 8'd1;
    end

    // Bar index tracks x / (H_ACTIVE/8) without a divider
    bar_px_d  = bar_px_q + 1'b1;
    bar_idx_d = bar_idx_q;
    if (x_wrap) begin
      bar_px_d  = '0;
      bar_idx_d = '0;
    end else if (bar_px_q == BAR_LAST) begin
      bar_px_d  = '0;
      bar_idx_d = bar_idx_q + 3'd1;
    end

    mode_d   = at_origin ? mode      : mode_q;
    scroll_d = at_origin ? scroll_en : scroll_q;
    solid_d  = at_origin ? solid_rgb : solid_q;
  end

  // Counter and frame-setting registers
  always_ff @(posedge pixclk) begin
    if (reset) begin
      x_q         <= '0;
      y_q         <= '0;
      bar_px_q    <= '0;
      bar_idx_q   <= '0;
      frame_cnt_q <= '0;
      mode_q      <= '0;
      scroll_q    <= 1'b0;
      solid_q     <= '0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      bar_px_q    <= bar_px_d;
      bar_idx_q   <= bar_idx_d;
      frame_cnt_q <= frame_cnt_d;
      mode_q      <= mode_d;
      scroll_q    <= scroll_d;
      solid_q     <= solid_d;
    end
  end

  // ---------------------------------------------------------------------
  // Pattern generation for the pixel at (x_q, y_q)
  // ---------------------------------------------------------------------
  logic               active_px;
  logic               left_px;
  logic               top_px;
  logic [7:0]         scroll_off;
  logic [XS_W-1:0]    xs;
  logic               chk_bit;
  logic [COLOR_W-1:0] pix_ch [3];

  // Region flags and the horizontally scrolled x used by checker and ramp
  always_comb begin
    active_px  = (x_q < H_ACT_L) && (y_q < V_ACT_L);
    left_px    = (x_q < H_HALF);
    top_px     = (y_q < V_HALF);
    scroll_off = scroll_d ? frame_cnt_q : 8'd0;
    xs         = XS_W'(x_q) + XS_W'(scroll_off);
    chk_bit    = xs[CHECK_LOG2] ^ y_q[CHECK_LOG2];
  end

  // One colour channel per iteration: 0 = red, 1 = green, 2 = blue
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_chan
      // Bar channel is full when this idx bit is clear (R:1, G:2, B:0)
      localparam int BAR_BIT   = (gi == 0) ? 1 : ((gi == 1) ? 2 : 0);
      localparam int SOLID_LSB = (2 - gi) * COLOR_W;
      localparam bit IS_R      = (gi == 0);
      localparam bit IS_G      = (gi == 1);
      localparam bit IS_B      = (gi == 2);

      logic               quad_on;
      logic [COLOR_W-1:0] pix;

      // Channel value for the selected pattern, blanked outside the active area
      always_comb begin
        // Bottom-right quadrant is white; the other three light one channel
        quad_on = (!left_px && !top_px)
                | (IS_R &&  left_px &&  top_px)
                | (IS_G && !left_px &&  top_px)
                | (IS_B &&  left_px && !top_px);
        pix = '0;
        if (active_px) begin
          case (mode_d)
            3'd0:    pix = quad_on ? FULL : '0;
            3'd1:    pix = bar_idx_q[BAR_BIT] ? '0 : FULL;
            3'd2:    pix = chk_bit ? '0 : FULL;
            3'd3:    pix = xs[COLOR_W-1:0];
            3'd4:    pix = solid_d[SOLID_LSB +: COLOR_W];
            default: pix = '0;
          endcase
        end
      end

      assign pix_ch[gi] = pix;
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Output pipeline register: everything for one pixel moves together
  // ---------------------------------------------------------------------
  logic [COLOR_W-1:0] red_q, red_d;
  logic [COLOR_W-1:0] green_q, green_d;
  logic [COLOR_W-1:0] blue_q, blue_d;
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic               de_q, de_d;
  logic [CNT_W-1:0]   cnt_x_q, cnt_x_d;
  logic [CNT_W-1:0]   cnt_y_q, cnt_y_d;
  logic               frame_start_q, frame_start_d;
  logic [7:0]         frame_cnt_o_q, frame_cnt_o_d;

  // Output values for the current raster position
  always_comb begin
    red_d         = pix_ch[0];
    green_d       = pix_ch[1];
    blue_d        = pix_ch[2];
    de_d          = active_px;
    hsync_d       = ((x_q >= HS_BEG) && (x_q < HS_END)) ? SYNC_POL : ~SYNC_POL;
    vsync_d       = ((y_q >= VS_BEG) && (y_q < VS_END)) ? SYNC_POL : ~SYNC_POL;
    cnt_x_d       = x_q;
    cnt_y_d       = y_q;
    frame_start_d = at_origin;
    frame_cnt_o_d = frame_cnt_q;
  end

  // Output registers; reset drives the idle (blanked, sync inactive) state
  always_ff @(posedge pixclk) begin
    if (reset) begin
      red_q         <= '0;
      green_q       <= '0;
      blue_q        <= '0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      de_q          <= 1'b0;
      cnt_x_q       <= '0;
      cnt_y_q       <= '0;
      frame_start_q <= 1'b0;
      frame_cnt_o_q <= '0;
    end else begin
      red_q         <= red_d;
      green_q       <= green_d;
      blue_q        <= blue_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      cnt_x_q       <= cnt_x_d;
      cnt_y_q       <= cnt_y_d;
      frame_start_q <= frame_start_d;
      frame_cnt_o_q <= frame_cnt_o_d;
    end
  end

  assign red         = red_q;
  assign green       = green_q;
  assign blue        = blue_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign cntX        = cnt_x_q;
  assign cntY        = cnt_y_q;
  assign frame_start = frame_start_q;
  assign frame_cnt   = frame_cnt_o_q;

endmodule

// File: tb/tb_hdmi_pattern_gen.sv
// Bench for hdmi_pattern_gen: a reduced-size main instance checked every
// cycle against a raster model, plus a tiny instance used for frame_cnt wrap.
module tb_hdmi_pattern_gen;

  // Main instance geometry (small so many frames fit in the run)
  localparam int HA = 64, HFP = 4, HSY = 8, HBP = 4;
  localparam int VA = 24, VFP = 2, VSY = 2, VBP = 2;
  localparam int HT = HA + HFP + HSY + HBP;   // 80
  localparam int VT = VA + VFP + VSY + VBP;   // 30
  localparam int FT = HT * VT;                // 2400
  localparam int CELL = 8;                    // 2^CHECK_LOG2

  // Tiny instance geometry
  localparam int SHT = 11, SVT = 5, SFT = SHT * SVT;

  logic pixclk = 1'b0;
  always #5 pixclk = ~pixclk;

  logic        reset = 1'b1;
  logic [2:0]  mode = 3'd0;
  logic        scroll_en = 1'b0;
  logic [23:0] solid_rgb = 24'h0;
  logic [7:0]  red, green, blue;
  logic        hsync, vsync, de, frame_start;
  logic [11:0] cntX, cntY;
  logic [7:0]  frame_cnt;

  hdmi_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .COLOR_W(8), .CNT_W(12), .CHECK_LOG2(3), .SYNC_POL(1'b0)
  ) dut (
    .pixclk(pixclk), .reset(reset), .mode(mode), .scroll_en(scroll_en),
    .solid_rgb(solid_rgb), .red(red), .green(green), .blue(blue),
    .hsync(hsync), .vsync(vsync), .de(de), .cntX(cntX), .cntY(cntY),
    .frame_start(frame_start), .frame_cnt(frame_cnt)
  );

  logic        reset2 = 1'b1;
  logic [3:0]  s_red, s_green, s_blue;
  logic        s_hsync, s_vsync, s_de, s_fs;
  logic [7:0]  s_cx, s_cy, s_fc;

  hdmi_pattern_gen #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .COLOR_W(4), .CNT_W(8), .CHECK_LOG2(1), .SYNC_POL(1'b1)
  ) dut_small (
    .pixclk(pixclk), .reset(reset2), .mode(3'd2), .scroll_en(1'b1),
    .solid_rgb(12'h000), .red(s_red), .green(s_green), .blue(s_blue),
    .hsync(s_hsync), .vsync(s_vsync), .de(s_de), .cntX(s_cx), .cntY(s_cy),
    .frame_start(s_fs), .frame_cnt(s_fc)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit done2    = 1'b0;

  typedef struct packed {
    logic [7:0]  r, g, b;
    logic        de, hs, vs, fs;
    logic [11:0] cx, cy;
    logic [7:0]  fc;
  } out_t;

  typedef struct {
    logic [2:0]  md;
    logic        sc;
    logic [23:0] sol;
    int          x, y, fc;
    logic [23:0] rgb;
    logic        de;
  } vec_t;

  // Bar colours left to right
  logic [23:0] bar_col [8] = '{24'hffffff, 24'hffff00, 24'h00ffff, 24'h00ff00,
                               24'hff00ff, 24'hff0000, 24'h0000ff, 24'h000000};

  // Expected output for pixel index t (pixels since reset release)
  function automatic out_t model_pixel(int t, logic [2:0] md, logic sc, logic [23:0] sol);
    out_t o;
    int x, y, f, xs;
    logic [23:0] c;
    x = t % HT;
    y = (t / HT) % VT;
    f = (t / FT) % 256;
    o = '0;
    o.cx = 12'(x);
    o.cy = 12'(y);
    o.fc = 8'(f);
    o.fs = (x == 0 && y == 0);
    o.hs = (x >= HA + HFP && x < HA + HFP + HSY) ? 1'b0 : 1'b1;
    o.vs = (y >= VA + VFP && y < VA + VFP + VSY) ? 1'b0 : 1'b1;
    o.de = (x < HA && y < VA);
    c = 24'h0;
    if (o.de) begin
      xs = (x + (sc ? f : 0)) % 4096;
      case (md)
        3'd0: begin
          if (y < VA / 2) c = (x < HA / 2) ? 24'hff0000 : 24'h00ff00;
          else            c = (x < HA / 2) ? 24'h0000ff : 24'hffffff;
        end
        3'd1: c = bar_col[x / (HA / 8)];
        3'd2: c = (((xs / CELL) + (y / CELL)) % 2 == 0) ? 24'hffffff : 24'h000000;
        3'd3: c = {3{8'(xs % 256)}};
        3'd4: c = sol;
        default: c = 24'h0;
      endcase
    end
    {o.r, o.g, o.b} = c;
    return o;
  endfunction

  // Model state
  int          m_t = 0;
  logic [2:0]  m_mode = 3'd0;
  logic        m_scr = 1'b0;
  logic [23:0] m_sol = 24'h0;
  int          m_x = 0, m_y = 0, m_f = 0;
  bit          m_live = 1'b0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  // Advance one clock and compare every output against the model
  task automatic step();
    out_t e, a;
    bit rst_s;
    rst_s = reset;
    if (!rst_s && (m_t % FT) == 0) begin
      m_mode = mode; m_scr = scroll_en; m_sol = solid_rgb;
    end
    @(posedge pixclk);
    #1;
    if (rst_s) begin
      e = '0; e.hs = 1'b1; e.vs = 1'b1;
      m_t = 0; m_mode = 3'd0; m_scr = 1'b0; m_sol = 24'h0; m_live = 1'b0;
    end else begin
      e = model_pixel(m_t, m_mode, m_scr, m_sol);
      m_x = m_t % HT; m_y = (m_t / HT) % VT; m_f = (m_t / FT) % 256;
      m_live = 1'b1;
      m_t++;
    end
    a.r = red; a.g = green; a.b = blue; a.de = de; a.hs = hsync; a.vs = vsync;
    a.fs = frame_start; a.cx = cntX; a.cy = cntY; a.fc = frame_cnt;
    n_checks++;
    if (a === e) n_pass++;
    else $display("FAIL pixel t=%0d: got rgb=%h%h%h de=%b hs=%b vs=%b fs=%b pos=(%0d,%0d) fc=%0d, expected rgb=%h%h%h de=%b hs=%b vs=%b fs=%b pos=(%0d,%0d) fc=%0d",
                  m_t, a.r, a.g, a.b, a.de, a.hs, a.vs, a.fs, a.cx, a.cy, a.fc,
                  e.r, e.g, e.b, e.de, e.hs, e.vs, e.fs, e.cx, e.cy, e.fc);
  endtask

  // Step until the model has just output pixel (x,y); bounded
  task automatic wait_pix(string nm, int x, int y, int budget);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < budget && !ok; k++) begin
      step();
      if (m_live && m_x == x && m_y == y) ok = 1'b1;
    end
    if (!ok) chk({nm, "_timeout"}, 64'd0, 64'd1);
  endtask

  vec_t vt [20];

  // Main sequence
  initial begin : main_run
    int cnt;
    bit ok;
    vt[0]  = '{3'd0, 1'b0, 24'h0, 64, 0, 0, 24'h000000, 1'b0};
    vt[1]  = '{3'd0, 1'b0, 24'h0, 31, 11, 0, 24'hff0000, 1'b1};
    vt[2]  = '{3'd0, 1'b0, 24'h0, 32, 11, 0, 24'h00ff00, 1'b1};
    vt[3]  = '{3'd0, 1'b0, 24'h0, 31, 12, 0, 24'h0000ff, 1'b1};
    vt[4]  = '{3'd0, 1'b0, 24'h0, 32, 12, 0, 24'hffffff, 1'b1};
    vt[5]  = '{3'd1, 1'b0, 24'h0, 0, 0, 1, 24'hffffff, 1'b1};
    vt[6]  = '{3'd1, 1'b0, 24'h0, 8, 0, 1, 24'hffff00, 1'b1};
    vt[7]  = '{3'd1, 1'b0, 24'h0, 40, 0, 1, 24'hff0000, 1'b1};
    vt[8]  = '{3'd1, 1'b0, 24'h0, 63, 0, 1, 24'h000000, 1'b1};
    vt[9]  = '{3'd2, 1'b0, 24'h0, 7, 0, 2, 24'hffffff, 1'b1};
    vt[10] = '{3'd2, 1'b0, 24'h0, 8, 0, 2, 24'h000000, 1'b1};
    vt[11] = '{3'd2, 1'b0, 24'h0, 0, 8, 2, 24'h000000, 1'b1};
    vt[12] = '{3'd2, 1'b0, 24'h0, 8, 8, 2, 24'hffffff, 1'b1};
    vt[13] = '{3'd2, 1'b1, 24'h0, 4, 0, 3, 24'hffffff, 1'b1};
    vt[14] = '{3'd2, 1'b1, 24'h0, 5, 0, 3, 24'h000000, 1'b1};
    vt[15] = '{3'd3, 1'b1, 24'h0, 37, 5, 4, 24'h292929, 1'b1};
    vt[16] = '{3'd4, 1'b0, 24'h123456, 10, 3, 5, 24'h123456, 1'b1};
    vt[17] = '{3'd5, 1'b0, 24'h0, 5, 5, 6, 24'h000000, 1'b1};
    vt[18] = '{3'd7, 1'b0, 24'h0, 63, 23, 7, 24'h000000, 1'b1};
    vt[19] = '{3'd0, 1'b0, 24'h0, 79, 29, 8, 24'h000000, 1'b0};

    // Reset held for 5 cycles: reset values every cycle
    repeat (5) step();
    chk("reset_hsync", {63'd0, hsync}, 64'd1);
    chk("reset_vsync", {63'd0, vsync}, 64'd1);

    // First output after release is pixel (0,0) with frame_start
    reset = 1'b0;
    step();
    chk("first_fs_de_pos", {38'd0, frame_start, de, cntX, cntY}, {38'd0, 1'b1, 1'b1, 12'd0, 12'd0});

    // Table of pattern points, each waited for in its own frame
    for (int i = 0; i < 20; i++) begin
      mode = vt[i].md; scroll_en = vt[i].sc; solid_rgb = vt[i].sol;
      ok = 1'b0;
      for (int k = 0; k < 3 * FT && !ok; k++) begin
        step();
        if (m_live && m_x == vt[i].x && m_y == vt[i].y && m_f == vt[i].fc &&
            m_mode == vt[i].md && m_scr == vt[i].sc && m_sol == vt[i].sol) ok = 1'b1;
      end
      if (!ok) chk($sformatf("vec%0d_timeout", i), 64'd0, 64'd1);
      else chk($sformatf("vec%0d_rgb_de", i), {39'd0, red, green, blue, de},
               {39'd0, vt[i].rgb, vt[i].de});
    end

    // Mid-frame mode change only takes effect at the next frame
    mode = 3'd0;
    wait_pix("midmode_a", 0, 10, FT + 5);
    mode = 3'd1;
    wait_pix("midmode_b", 40, 15, FT + 5);
    chk("midmode_same_frame", {40'd0, red, green, blue}, {40'd0, 24'hffffff});
    wait_pix("midmode_c", 8, 0, FT + 5);
    chk("midmode_next_frame", {40'd0, red, green, blue}, {40'd0, 24'hffff00});

    // Frame length between frame_start pulses
    ok = 1'b0;
    for (int k = 0; k < FT + 5 && !ok; k++) begin
      step();
      if (frame_start) ok = 1'b1;
    end
    cnt = 0;
    if (ok) begin
      ok = 1'b0;
      for (int k = 0; k < FT + 5 && !ok; k++) begin
        step();
        cnt++;
        if (frame_start) ok = 1'b1;
      end
    end
    chk("frame_length", 64'(cnt), 64'(FT));

    // Randomised inputs, changes often landing on the frame-start cycle
    for (int k = 0; k < 12 * FT; k++) begin
      if (((m_t % FT) == 0 && $urandom_range(0, 1) == 1) || $urandom_range(0, 399) == 0) begin
        mode      = 3'($urandom_range(0, 7));
        scroll_en = 1'($urandom_range(0, 1));
        solid_rgb = 24'($urandom());
      end
      step();
    end

    // Reset mid-frame, then restart at (0,0) with new settings
    mode = 3'd3; scroll_en = 1'b1;
    wait_pix("midreset", 30, 10, FT + 5);
    reset = 1'b1;
    step();
    chk("midreset_vals", {39'd0, de, cntX, cntY}, 64'd0);
    step();
    reset = 1'b0; mode = 3'd4; scroll_en = 1'b0; solid_rgb = 24'habcdef;
    step();
    chk("restart_fs_fc", {55'd0, frame_start, frame_cnt}, {55'd0, 1'b1, 8'd0});
    chk("restart_solid", {40'd0, red, green, blue}, {40'd0, 24'habcdef});
    mode = 3'd2;
    repeat (FT + 10) step();

    for (int k = 0; k < 40000 && !done2; k++) @(posedge pixclk);
    if (!done2) chk("small_done_timeout", 64'd0, 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Tiny instance: SYNC_POL=1, scrolling checker, frame_cnt wrap after 256 frames
  initial begin : small_run
    int x, y, f, xs;
    logic [3:0] w;
    repeat (3) @(posedge pixclk);
    #1;
    chk("small_reset_sync", {62'd0, s_hsync, s_vsync}, 64'd0);
    reset2 = 1'b0;
    for (int t = 0; t < 257 * SFT + 3; t++) begin
      @(posedge pixclk);
      #1;
      x = t % SHT; y = (t / SHT) % SVT; f = (t / SFT) % 256;
      xs = (x + f) % 256;
      w = (x < 8 && y < 2 && ((xs / 2) + (y / 2)) % 2 == 0) ? 4'hf : 4'h0;
      chk($sformatf("small_t%0d", t),
          {24'd0, s_red, s_green, s_blue, s_de, s_hsync, s_vsync, s_fs, s_cx, s_cy, s_fc},
          {24'd0, w, w, w, 1'(x < 8 && y < 2), 1'(x == 9), 1'(y == 3),
           1'(x == 0 && y == 0), 8'(x), 8'(y), 8'(f)});
    end
    done2 = 1'b1;
  end

endmodule
